vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//  Free-running VGA raster timing generator; head of the video pipeline.
//  Produces hcount/vcount, sync and blank strobes for one pixel clock domain.
//  Output feeds the first draw stage (background / rect / numeric overlays) directly.
//  Defaults give 800x600@60 Hz (40 MHz pixel clock), positive sync polarity.
// PARAMETERS
//  H_ACTIVE  800   visible pixels per line
//  H_FP      40    horizontal front porch (clocks)
//  H_SYNC    128   hsync pulse width (clocks)
//  H_BP      88    horizontal back porch (clocks)
//  V_ACTIVE  600   visible lines per frame
//  V_FP      1     vertical front porch (lines)
//  V_SYNC    4     vsync pulse width (lines)
//  V_BP      23    vertical back porch (lines)
//  (derived: H_TOTAL = sum of H_* = 1056, V_TOTAL = sum of V_* = 628; all must be >= 1)
// PORTS
//  clk          in   1   pixel clock; all logic on posedge
//  rst          in   1   asynchronous, active-high reset
//  hcount_out   out  11  current pixel column, 0..H_TOTAL-1
//  hsync_out    out  1   horizontal sync, active high
//  hblnk_out    out  1   horizontal blank, high outside active columns
//  vcount_out   out  11  current line, 0..V_TOTAL-1
//  vsync_out    out  1   vertical sync, active high
//  vblnk_out    out  1   vertical blank, high outside active lines
//  frame_start  out  1   one-clock pulse when (hcount,vcount) = (0,0)
// BEHAVIOUR
//  - Reset (rst=1, async): every output = 0, held until rst deasserts.
//  - First posedge after rst falls: hcount_out 0->1. No extra pipeline latency.
//  - Horizontal counter: +1 per clk; at H_TOTAL-1 wraps to 0 on the next edge.
//  - Vertical counter: advances only on the edge where hcount wraps.
//    - At V_TOTAL-1 it wraps to 0 on that same edge.
//    - Last pixel (H_TOTAL-1, V_TOTAL-1) -> (0,0) in one edge.
//  - All outputs are registers. Each strobe is decoded from the next-state counts,
//    so strobes always describe the hcount_out/vcount_out value in the same cycle.
//    No skew between counts and strobes.
//  - hblnk_out = 1 iff hcount_out >= H_ACTIVE.
//  - hsync_out = 1 iff H_ACTIVE+H_FP <= hcount_out < H_ACTIVE+H_FP+H_SYNC  (840..967).
//  - vblnk_out = 1 iff vcount_out >= V_ACTIVE.
//  - vsync_out = 1 iff V_ACTIVE+V_FP <= vcount_out < V_ACTIVE+V_FP+V_SYNC  (601..604).
//  - vsync/vblnk change only together with vcount, i.e. at hcount = 0.
//  - frame_start = 1 iff counts are (0,0) and not in reset.
//    The reset-held (0,0) cycle shows 0; the pulse first fires after the first full frame.
//  - Reset mid-frame: outputs go to 0 immediately (async).
//    Counting restarts from (0,0) with no residual state.
//  - Width rule: counts are 11 bits. H_TOTAL and V_TOTAL must be <= 2048.
//    An elaboration-time check errors otherwise.
//  - Blank and sync are mutually consistent: sync is asserted only while the same-axis blank is 1.
// TESTING
//  1 Reset: assert rst mid-line at hcount=500 -> all outputs 0 same cycle;
//    release -> hcount 1 after first edge.
//  2 Line timing: run one line -> hblnk rises at hcount=800; hsync high 840..967 (128 clks);
//    hcount 1055->0 with vcount +1.
//  3 Frame timing: run full frame -> vblnk high lines 600..627; vsync high lines 601..604;
//    frame period = 1056*628 = 663168 clks.
//  4 Wrap: at (1055,627) -> next edge (0,0), frame_start=1 for exactly one clock, vblnk 1->0.
//  5 Checker: every cycle compare all outputs against a reference model computed from counts;
//    zero mismatches over 3 frames.
//  6 Param override (H 16/2/3/2, V 8/1/1/1): line = 23 clks, frame = 11 lines;
//    strobes at the scaled positions.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator: pixel/line counters plus sync, blank
// and frame-start strobes, all registered and aligned with the counts they describe.
module vga_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] hcount_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic [10:0] vcount_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 2048 || V_TOTAL > 2048 ||
        H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_params
        $error("vga_timing_gen: timing parameters must be >= 1 and totals must fit 11 bits");
    end

    localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT        = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT        = 11'(V_ACTIVE);
    localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_SYNC_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    function automatic logic in_span(input logic [10:0] x,
                                     input logic [10:0] lo,
                                     input logic [10:0] hi);
        return (x >= lo) && (x < hi);
    endfunction

    logic [10:0] h_next;
    logic [10:0] v_next;

    always_comb begin
        h_next = hcount_out + 11'd1;
        v_next = vcount_out;
        if (hcount_out == H_LAST) begin
            h_next = '0;
            v_next = (vcount_out == V_LAST) ? 11'd0 : vcount_out + 11'd1;
        end
    end

    // Strobes are decoded from the next counts so they land in the same cycle as the counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount_out  <= '0;
            vcount_out  <= '0;
            hsync_out   <= 1'b0;
            hblnk_out   <= 1'b0;
            vsync_out   <= 1'b0;
            vblnk_out   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hcount_out  <= h_next;
            vcount_out  <= v_next;
            hblnk_out   <= (h_next >= H_ACT);
            hsync_out   <= in_span(h_next, H_SYNC_START, H_SYNC_END);
            vblnk_out   <= (v_next >= V_ACT);
            vsync_out   <= in_span(v_next, V_SYNC_START, V_SYNC_END);
            frame_start <= (h_next == 11'd0) && (v_next == 11'd0);
        end
    end

endmodule
